// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch queue.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP         = 32'd4;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of (instr, pc) pairs.
// Pointers wrap naturally because DEPTH is a power of two; clear wins over push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          push_i,
   input  fetch_entry_t  wdata_i,
   input  logic          pop_i,
   output fetch_entry_t  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i)  rptr_q <= rptr_q + 1'b1;
         if (push_i && !pop_i)      count_q <= count_q + 1'b1;
         else if (!push_i && pop_i) count_q <= count_q - 1'b1;
      end
   end

   // Storage is not reset; the head is only observed while count is non-zero
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetcher with in-order response buffering
// and redirect flush. Optional macro FETCH_QUEUE_BYPASS_EN forwards a response
// straight to the core when the FIFO is empty (zero-latency path).
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t  state_q;
   logic [31:0]   fetch_pc_q, rsp_pc_q, target;
   logic [CW-1:0] inflight_q, discard_q, flush_left, count;
   logic [CW:0]   credit_used;
   logic          in_fetch, redirect_hit, req_fire, rsp_take;
   logic          push, pop, bypass, fifo_empty, fifo_full;
   fetch_entry_t  head, wdata;

   assign in_fetch     = (state_q == FETCH);
   assign redirect_hit = redirect_valid && (state_q != IDLE);
   assign target       = align_pc(redirect_pc);

   // Outstanding requests plus buffered entries never exceed DEPTH, so every
   // response always has a FIFO slot. Valid is combinational so that a redirect
   // withdraws a pending request in the same cycle.
   assign credit_used    = {1'b0, inflight_q} + {1'b0, count};
   assign imem_req_valid = in_fetch && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses only count as instructions in FETCH and outside a redirect cycle
   assign rsp_take = in_fetch && imem_rsp_valid && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = rsp_take && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = !fifo_empty || bypass;
   assign instr       = bypass ? imem_rsp_data : (fifo_empty ? 32'h0 : head.instr);
   assign instr_pc    = bypass ? rsp_pc_q      : (fifo_empty ? 32'h0 : head.pc);

   assign pop   = !fifo_empty && instr_ready && !redirect_valid;
   assign push  = rsp_take && !(bypass && instr_ready);
   assign wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};

   // Remaining responses to drop after this cycle while flushing
   assign flush_left = (imem_rsp_valid && discard_q != '0) ? discard_q - 1'b1 : discard_q;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (redirect_hit),
      .push_i  (push),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Fetch control FSM with outstanding/discard counters and PC tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         if (redirect_hit) begin
            fetch_pc_q <= target;
            rsp_pc_q   <= target;
         end else begin
            if (req_fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
            if (rsp_take) rsp_pc_q   <= rsp_pc_q + PC_STEP;
         end
         case (state_q)
            IDLE: state_q <= FETCH;
            FETCH: begin
               if (redirect_valid) begin
                  // A response arriving in the redirect cycle is already dropped
                  inflight_q <= '0;
                  discard_q  <= inflight_q - CW'(imem_rsp_valid);
                  if (inflight_q != '0) state_q <= FLUSH;
               end else if (req_fire && !imem_rsp_valid) begin
                  inflight_q <= inflight_q + 1'b1;
               end else if (!req_fire && imem_rsp_valid) begin
                  inflight_q <= inflight_q - 1'b1;
               end
            end
            FLUSH: begin
               discard_q <= flush_left;
               if (flush_left == '0) state_q <= FETCH;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory must not respond into a full FIFO
   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule
